// File: rtl/eth_pkg.sv
// eth_pkg
// Shared definitions for the Ethernet II frame builder: header and minimum
// payload lengths, the builder FSM state type, and a helper that picks one
// byte out of a 48-bit MAC address, most significant byte first.
package eth_pkg;

    localparam int ETH_HDR_LEN     = 14;
    localparam int ETH_MIN_PAYLOAD = 46;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MAC,
        HDR,
        PAYLOAD,
        PAD,
        TAIL,
        DRAIN
    } fb_state_t;

    // Byte i (0..5) of a MAC address, byte 0 being bits 47:40.
    function automatic logic [7:0] mac_byte(input logic [47:0] addr48, input int i);
        logic [47:0] shifted;
        shifted = addr48 >> (8 * (5 - i));
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/eth_frame_builder_if.sv
// eth_frame_builder_if
// Groups the payload stream (PL_DATA/PL_VALID/PL_LAST/PL_READY) and the MAC
// send interface (SEND_DATA/SEND_EN/SENT_BUSY) of the frame builder.
//   slave  : the frame builder side (consumes payload, drives the MAC)
//   master : the environment side (produces payload, acts as the MAC)
interface eth_frame_builder_if;

    logic [7:0] PL_DATA;
    logic       PL_VALID;
    logic       PL_LAST;
    logic       PL_READY;
    logic [7:0] SEND_DATA;
    logic       SEND_EN;
    logic       SENT_BUSY;

    modport slave (
        input  PL_DATA, PL_VALID, PL_LAST, SENT_BUSY,
        output PL_READY, SEND_DATA, SEND_EN
    );

    modport master (
        output PL_DATA, PL_VALID, PL_LAST, SENT_BUSY,
        input  PL_READY, SEND_DATA, SEND_EN
    );

endinterface

// File: rtl/frame_payload_ram.sv
// frame_payload_ram
// Simple dual-port byte RAM, single clock. Synchronous write; synchronous
// read with one cycle of latency (rd_data reflects rd_addr of the previous
// edge).
//   CLK     : clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write byte
//   rd_addr : read address
//   rd_data : registered read byte
module frame_payload_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/eth_frame_builder.sv
// eth_frame_builder
// Buffers one payload from a byte stream and then emits an Ethernet II frame
// (no FCS) to the MII transmit MAC: DST_MAC, SRC_MAC, ETHERTYPE, payload,
// zero padding up to 46 payload bytes.
//   CLK        : clock
//   RST        : synchronous active-high reset
//   bus        : payload stream in, SEND_DATA/SEND_EN out, SENT_BUSY in
//   BUILD_BUSY : high from LAST acceptance until the MAC finishes the frame
//   OVERFLOW   : sticky, payload exceeded MAX_PAYLOAD; cleared by the first
//                accepted byte of the next payload
module eth_frame_builder
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h0007_ED11_2233,
    parameter logic [15:0] ETHERTYPE   = 16'h0800,
    parameter int          MAX_PAYLOAD = 256,
    parameter int          ADDR_W      = 11
) (
    input  logic                 CLK,
    input  logic                 RST,
    eth_frame_builder_if.slave   bus,
    output logic                 BUILD_BUSY,
    output logic                 OVERFLOW
);

    localparam int                RAM_AW   = $clog2(MAX_PAYLOAD);
    localparam logic [ADDR_W-1:0] MAX_LEN  = ADDR_W'(MAX_PAYLOAD);
    localparam logic [ADDR_W-1:0] HDR_LAST = ADDR_W'(ETH_HDR_LEN - 1);
    localparam logic [ADDR_W-1:0] MIN_LEN  = ADDR_W'(ETH_MIN_PAYLOAD);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    fb_state_t         state;
    logic [ADDR_W-1:0] wr_len;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] pad_last;
    logic              pl_ready;
    logic              send_en;
    logic [7:0]        send_data;
    logic              build_busy;
    logic              overflow;
    logic              seen_busy;
    logic              accept;
    logic              ram_we;
    logic [7:0]        rd_data;

    assign accept = (state == IDLE) && pl_ready && bus.PL_VALID;
    // Bytes beyond MAX_PAYLOAD are accepted but never written.
    assign ram_we = accept && (wr_len < MAX_LEN);

    frame_payload_ram #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (RAM_AW)
    ) u_ram (
        .CLK     (CLK),
        .we      (ram_we),
        .wr_addr (wr_len[RAM_AW-1:0]),
        .wr_data (bus.PL_DATA),
        .rd_addr (rd_addr[RAM_AW-1:0]),
        .rd_data (rd_data)
    );

    function automatic logic [7:0] hdr_byte(input logic [ADDR_W-1:0] i);
        int k;
        k = int'(i);
        if (k < 6) begin
            return mac_byte(DST_MAC, k);
        end else if (k < 12) begin
            return mac_byte(SRC_MAC, k - 6);
        end else if (k == 12) begin
            return ETHERTYPE[15:8];
        end
        return ETHERTYPE[7:0];
    endfunction

    // Frame builder FSM. All outputs are registered here so SEND_EN and
    // SEND_DATA change on the same edge. The RAM read address runs one
    // ahead of the byte being driven to hide the RAM read latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            wr_len     <= '0;
            len        <= '0;
            idx        <= '0;
            rd_addr    <= '0;
            pad_last   <= '0;
            pl_ready   <= 1'b0;
            send_en    <= 1'b0;
            send_data  <= 8'h00;
            build_busy <= 1'b0;
            overflow   <= 1'b0;
            seen_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pl_ready <= 1'b1;
                    if (accept) begin
                        if (wr_len == '0) begin
                            overflow <= 1'b0;
                        end
                        if (wr_len < MAX_LEN) begin
                            wr_len <= wr_len + ONE;
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (bus.PL_LAST) begin
                            len        <= (wr_len < MAX_LEN) ? wr_len + ONE : wr_len;
                            pl_ready   <= 1'b0;
                            build_busy <= 1'b1;
                            state      <= WAIT_MAC;
                        end
                    end
                end
                WAIT_MAC: begin
                    if (!bus.SENT_BUSY) begin
                        rd_addr <= '0;
                        idx     <= '0;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    send_en   <= 1'b1;
                    send_data <= hdr_byte(idx);
                    if (idx == HDR_LAST) begin
                        idx     <= '0;
                        rd_addr <= rd_addr + ONE;
                        state   <= PAYLOAD;
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                PAYLOAD: begin
                    send_en   <= 1'b1;
                    send_data <= rd_data;
                    rd_addr   <= rd_addr + ONE;
                    if (idx == len - ONE) begin
                        idx <= '0;
                        if (len < MIN_LEN) begin
                            pad_last <= MIN_LEN - len - ONE;
                            state    <= PAD;
                        end else begin
                            state <= TAIL;
                        end
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                PAD: begin
                    send_en   <= 1'b1;
                    send_data <= 8'h00;
                    if (idx == pad_last) begin
                        state <= TAIL;
                    end else begin
                        idx <= idx + ONE;
                    end
                end
                TAIL: begin
                    send_en   <= 1'b0;
                    seen_busy <= 1'b0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    // The MAC must be seen busy and then idle again.
                    if (bus.SENT_BUSY) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        wr_len     <= '0;
                        build_busy <= 1'b0;
                        pl_ready   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.PL_READY  = pl_ready;
    assign bus.SEND_EN   = send_en;
    assign bus.SEND_DATA = send_data;
    assign BUILD_BUSY    = build_busy;
    assign OVERFLOW      = overflow;

endmodule
